// File: rtl/hamming_serial_rx.sv
// Serial Hamming(12,8) receiver: LSB-first codeword in, single-error-corrected byte out.
// data_valid rises two edges after the 12th bit; the result holds until data_ready.
module hamming_serial_rx #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_start,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  input  logic       endereco_in,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       endereco_out,
  output logic [3:0] syndrome,
  output logic       corrected,
  output logic       uncorrectable,
  output logic       frame_error,
  output logic       busy
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

  state_t        state;
  logic [11:0]   sr;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic          addr_q;

  logic [3:0]    syn;
  logic [7:0]    raw_dat;
  logic [7:0]    flip;
  logic          syn_fix;
  logic          syn_bad;

  always_comb begin
    syn[0]  = sr[0] ^ sr[2] ^ sr[4] ^ sr[6] ^ sr[8] ^ sr[10];
    syn[1]  = sr[1] ^ sr[2] ^ sr[5] ^ sr[6] ^ sr[9] ^ sr[10];
    syn[2]  = sr[3] ^ sr[4] ^ sr[5] ^ sr[6] ^ sr[11];
    syn[3]  = sr[7] ^ sr[8] ^ sr[9] ^ sr[10] ^ sr[11];
    raw_dat = {sr[11], sr[10], sr[9], sr[8], sr[6], sr[5], sr[4], sr[2]};
    syn_fix = (syn != 4'd0) && (syn <= 4'd12);
    syn_bad = (syn >= 4'd13);
    // Only syndromes pointing at data positions change the byte; parity hits leave it alone.
    flip = 8'h00;
    case (syn)
      4'd3:    flip = 8'h01;
      4'd5:    flip = 8'h02;
      4'd6:    flip = 8'h04;
      4'd7:    flip = 8'h08;
      4'd9:    flip = 8'h10;
      4'd10:   flip = 8'h20;
      4'd11:   flip = 8'h40;
      4'd12:   flip = 8'h80;
      default: flip = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sr            <= 12'h000;
      bit_cnt       <= 4'd0;
      idle_cnt      <= '0;
      addr_q        <= 1'b0;
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      endereco_out  <= 1'b0;
      syndrome      <= 4'h0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_start) begin
            state    <= SHIFT;
            bit_cnt  <= 4'd0;
            idle_cnt <= '0;
            addr_q   <= endereco_in;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          // bit_cnt==12 is the one settle cycle between the last bit and CHECK.
          if (bit_cnt == 4'd12) begin
            state <= CHECK;
          end else if (rx_bit_valid) begin
            sr       <= {rx_bit, sr[11:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
            idle_cnt    <= '0;
            bit_cnt     <= 4'd0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK: begin
          state         <= HOLD;
          data_out      <= raw_dat ^ flip;
          syndrome      <= syn;
          corrected     <= syn_fix;
          uncorrectable <= syn_bad;
          endereco_out  <= addr_q;
          data_valid    <= 1'b1;
        end
        HOLD: begin
          if (data_ready) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: codeword table plus backpressure, timeout and reset sequences.
module tb_hamming_serial_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_start;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       endereco_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       endereco_out;
  logic [3:0] syndrome;
  logic       corrected;
  logic       uncorrectable;
  logic       frame_error;
  logic       busy;

  int total = 0;
  int bad   = 0;

  hamming_serial_rx #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_start     (rx_start),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .endereco_in  (endereco_in),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .endereco_out (endereco_out),
    .syndrome     (syndrome),
    .corrected    (corrected),
    .uncorrectable(uncorrectable),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cw;
    logic        addr;
    int          gap_at;
    logic [7:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        unc;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start pulse carries a junk valid bit that must not be accepted; endereco_in flips after the start.
  task automatic send_frame(input logic [11:0] cw, input logic addr, input int gap_at);
    rx_start     = 1'b1;
    endereco_in  = addr;
    rx_bit_valid = 1'b1;
    rx_bit       = 1'b1;
    tick();
    rx_start    = 1'b0;
    endereco_in = ~addr;
    for (int i = 0; i < 12; i++) begin
      if (i == gap_at) begin
        rx_bit_valid = 1'b0;
        tick();
        tick();
      end
      rx_bit_valid = 1'b1;
      rx_bit       = cw[i];
      tick();
    end
    rx_bit_valid = 1'b0;
    rx_bit       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{12'hA27, 1'b1, -1, 8'hA5, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{12'hA07, 1'b0, -1, 8'hA5, 4'd6,  1'b1, 1'b0};
    vecs[2] = '{12'hE07, 1'b1, 6,  8'hE1, 4'd13, 1'b0, 1'b1};
    vecs[3] = '{12'hA26, 1'b0, -1, 8'hA5, 4'd1,  1'b1, 1'b0};
    vecs[4] = '{12'h227, 1'b1, 3,  8'hA5, 4'd12, 1'b1, 1'b0};
    vecs[5] = '{12'h000, 1'b0, -1, 8'h00, 4'd0,  1'b0, 1'b0};
    vecs[6] = '{12'hF77, 1'b1, -1, 8'hFF, 4'd0,  1'b0, 1'b0};
    vecs[7] = '{12'h773, 1'b0, -1, 8'h7E, 4'd15, 1'b0, 1'b1};

    reset        = 1'b1;
    rx_start     = 1'b0;
    rx_bit       = 1'b0;
    rx_bit_valid = 1'b0;
    endereco_in  = 1'b0;
    data_ready   = 1'b0;
    #1;
    check("rst_outputs", {data_out, syndrome, endereco_out, data_valid, corrected,
                          uncorrectable, frame_error, busy}, 32'h0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;

    // Valid bits while idle must not disturb the next frame.
    rx_bit_valid = 1'b1;
    rx_bit       = 1'b1;
    tick();
    tick();
    rx_bit_valid = 1'b0;
    check("idle_busy", busy, 1'b0);

    foreach (vecs[v]) begin
      send_frame(vecs[v].cw, vecs[v].addr, vecs[v].gap_at);
      tick();
      check($sformatf("v%0d_lat1_valid", v), data_valid, 1'b0);
      tick();
      check($sformatf("v%0d_lat2_valid", v), data_valid, 1'b1);
      check($sformatf("v%0d_data", v), data_out, vecs[v].data);
      check($sformatf("v%0d_syn", v), syndrome, vecs[v].syn);
      check($sformatf("v%0d_corr", v), corrected, vecs[v].corr);
      check($sformatf("v%0d_unc", v), uncorrectable, vecs[v].unc);
      check($sformatf("v%0d_addr", v), endereco_out, vecs[v].addr);
      check($sformatf("v%0d_busy", v), busy, 1'b1);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check($sformatf("v%0d_release", v), {data_valid, busy}, 2'b00);
    end

    // Backpressure: hold for 10 cycles while start and bits are thrown at the block.
    send_frame(12'hA27, 1'b1, -1);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      rx_start     = (k % 2 == 0);
      rx_bit_valid = 1'b1;
      rx_bit       = (k % 3 == 0);
      tick();
      check($sformatf("bp_hold%0d", k),
            {data_valid, busy, data_out, syndrome, corrected, uncorrectable, endereco_out},
            {1'b1, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b0, 1'b1});
    end
    rx_start     = 1'b1;
    rx_bit_valid = 1'b0;
    data_ready   = 1'b1;
    tick();
    rx_start   = 1'b0;
    data_ready = 1'b0;
    check("bp_release", {data_valid, busy}, 2'b00);
    tick();
    check("bp_start_dropped", busy, 1'b0);

    // Timeout: 5 bits then silence; abort on the 64th idle cycle.
    begin
      int fe_cnt;
      fe_cnt   = 0;
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        rx_bit_valid = 1'b1;
        rx_bit       = i[0];
        tick();
      end
      rx_bit_valid = 1'b0;
      for (int c = 0; c < 63; c++) begin
        tick();
        fe_cnt += int'(frame_error);
      end
      check("to_busy_63", busy, 1'b1);
      check("to_no_fe_63", fe_cnt, 0);
      tick();
      check("to_abort", {busy, frame_error, data_valid}, 3'b010);
      tick();
      check("to_fe_pulse", {busy, frame_error, data_valid}, 3'b000);
    end

    // Reset during the 7th bit, then a clean frame straight after release.
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit       = ~i[0];
      tick();
    end
    rx_bit = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", {data_out, syndrome, endereco_out, data_valid, corrected,
                              uncorrectable, frame_error, busy}, 32'h0);
    rx_bit_valid = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
    send_frame(12'hA27, 1'b0, -1);
    tick();
    tick();
    check("post_rst_valid", data_valid, 1'b1);
    check("post_rst_data", data_out, 8'hA5);
    check("post_rst_syn", {syndrome, corrected, uncorrectable, endereco_out}, 7'h00);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("post_rst_release", {data_valid, busy}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_serial_rx.md
HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, idle cycles allowed between bits mid-frame before abort.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_start  input  1  one-cycle pulse marking the start of a codeword frame.
REQ-005 rx_bit  input  1  serial codeword bit; sampled only when rx_bit_valid=1.
REQ-006 rx_bit_valid  input  1  qualifies rx_bit.
REQ-007 endereco_in  input  1  destination slave select; latched on an accepted rx_start.
REQ-008 data_ready  input  1  downstream accepts the data_out/data_valid beat.
REQ-009 data_out  output  8  corrected message byte.
REQ-010 data_valid  output  1  data_out and the status outputs are valid.
REQ-011 endereco_out  output  1  latched endereco_in for the frame on data_out.
REQ-012 syndrome  output  4  computed syndrome for the frame on data_out.
REQ-013 corrected  output  1  a single-bit error was corrected.
REQ-014 uncorrectable  output  1  syndrome was 13..15; data_out is the uncorrected data bits.
REQ-015 frame_error  output  1  one-cycle pulse on a timeout abort.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, SHIFT, CHECK, HOLD.
REQ-018 IDLE -> SHIFT on rx_start=1; the bit counter clears to 0 and endereco_in is latched.
REQ-019 rx_start in SHIFT, CHECK or HOLD is ignored.
REQ-020 A bit is accepted in SHIFT on each cycle with rx_bit_valid=1.
REQ-021 The first bit accepted is codeword index 0 (LSB first); 12 bits make one frame.
REQ-022 An rx_bit_valid on the same cycle as rx_start is not accepted.
REQ-023 rx_bit_valid outside SHIFT is ignored.
REQ-024 Codeword layout: parity bits at indices 0, 1, 3, 7.
REQ-025 Codeword layout: data bits d0..d7 at indices 2, 4, 5, 6, 8, 9, 10, 11.
REQ-026 When the 12th bit is accepted, SHIFT -> CHECK on the next edge.
REQ-027 Syndrome bit s0 = XOR of codeword indices 0, 2, 4, 6, 8, 10.
REQ-028 Syndrome bit s1 = XOR of codeword indices 1, 2, 5, 6, 9, 10.
REQ-029 Syndrome bit s2 = XOR of codeword indices 3, 4, 5, 6, 11.
REQ-030 Syndrome bit s3 = XOR of codeword indices 7, 8, 9, 10, 11; syndrome = {s3,s2,s1,s0}.
REQ-031 CHECK, syndrome S=0: data_out = data bits unchanged; corrected=0, uncorrectable=0.
REQ-032 CHECK, S in 1..12: codeword index S-1 is inverted before data extraction; corrected=1, uncorrectable=0.
REQ-033 CHECK, S in 13..15: no bit is inverted; uncorrectable=1, corrected=0.
REQ-034 CHECK -> HOLD after exactly one cycle.
REQ-035 Latency: data_valid rises two edges after the edge that accepts the 12th bit.
REQ-036 In HOLD, data_valid=1; all outputs stay stable until the first cycle with data_ready=1.
REQ-037 HOLD -> IDLE on the edge where data_ready=1; data_valid falls on that edge.
REQ-038 rx_start and data_ready high on the same cycle in HOLD: the beat completes and the start is dropped.
REQ-039 Timeout: the idle counter counts SHIFT cycles with rx_bit_valid=0 and clears on each accepted bit.
REQ-040 When the idle counter reaches TIMEOUT_CYCLES: SHIFT -> IDLE, one-cycle frame_error pulse, partial frame discarded, data_valid stays 0.
REQ-041 The bit counter and idle counter never exceed their range.

Reset
REQ-042 While reset is asserted: FSM=IDLE and both counters=0.
REQ-043 While reset is asserted: data_out=8'h00, syndrome=4'h0, endereco_out=0.
REQ-044 While reset is asserted: data_valid, corrected, uncorrectable, frame_error and busy are all 0.
REQ-045 Reset asserted mid-SHIFT or mid-HOLD aborts the frame immediately; a pending beat is lost.
REQ-046 After release, the block accepts a new rx_start on the first edge.

Verification
REQ-047 Clean frame: endereco_in=1, bits of 12'hA27 LSB first -> data_out=8'hA5, syndrome=0, corrected=0, endereco_out=1, data_valid 2 edges after the 12th bit.
REQ-048 Single error: 12'hA27 with index 5 flipped (12'hA07) -> syndrome=6, data_out=8'hA5, corrected=1.
REQ-049 Double error: 12'hA27 with indices 5 and 10 flipped -> syndrome=13, uncorrectable=1, data_out=8'hE1.
REQ-050 Backpressure: data_ready=0 for 10 cycles -> outputs stable, extra rx_start ignored; HOLD -> IDLE on the first data_ready=1 cycle.
REQ-051 Timeout: 5 bits sent, then rx_bit_valid=0 for 64 cycles -> frame_error pulses once, busy=0, no data_valid.
REQ-052 Reset at the 7th bit, then a clean 12'hA27 frame -> data_out=8'hA5, syndrome=0, no residue from the aborted frame.
